// File: rtl/kuznechik_pkg.sv
// Shared types, constant tables and GF(2^8) arithmetic for the Kuznyechik core.
package kuznechik_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEY    = 3'd1,
    S      = 3'd2,
    L      = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int NUM_ROUND_KEYS = 10;

  // Index 0 is the leftmost (most significant) entry of the packed table
  typedef logic [0:255][7:0] sbox_t;

  localparam sbox_t S_BOX = {
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // The inverse table is derived from the forward one so the two can never disagree
  function automatic sbox_t invert_sbox(input sbox_t fwd);
    sbox_t inv;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      inv[fwd[i]] = 8'(i);
    end
    return inv;
  endfunction

  localparam sbox_t S_BOX_INV = invert_sbox(S_BOX);

  // Coefficient of byte a(15-k) in the linear form, k = 0..15
  localparam logic [0:15][7:0] L_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // Shift-and-add multiply in GF(2^8) reduced by x^8+x^7+x^6+x+1 (0x1C3)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/kuznechik_cipher_param_if.sv
// Host-side request/ack and round-key write bus of the Kuznyechik core.
interface kuznechik_cipher_param_if;

  logic         request_i;
  logic         decrypt_i;
  logic [127:0] data_i;
  logic         ack_i;
  logic         key_we_i;
  logic [3:0]   key_addr_i;
  logic [127:0] key_data_i;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] data_o;

  modport master (
    output request_i, decrypt_i, data_i, ack_i, key_we_i, key_addr_i, key_data_i,
    input  busy_o, valid_o, data_o
  );

  modport slave (
    input  request_i, decrypt_i, data_i, ack_i, key_we_i, key_addr_i, key_data_i,
    output busy_o, valid_o, data_o
  );

endinterface

// File: rtl/kuznechik_r_step.sv
// One combinational Kuznyechik R-step (forward or inverse) on a 128-bit state.
module kuznechik_r_step
  import kuznechik_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  if (INVERSE) begin : gInv
    logic [7:0] acc;
    // Recover the byte shifted out: top byte cancels the linear form of the rest
    always_comb begin
      acc = data_i[127:120];
      for (int j = 0; j < 15; j++) begin
        acc = acc ^ gf_mul(data_i[8*j +: 8], L_COEF[4'(14 - j)]);
      end
      data_o = {data_i[119:0], acc};
    end
  end else begin : gFwd
    logic [7:0] acc;
    // Linear form over all 16 bytes becomes the new top byte, the rest shifts down
    always_comb begin
      acc = '0;
      for (int j = 0; j < 16; j++) begin
        acc = acc ^ gf_mul(data_i[8*j +: 8], L_COEF[4'(15 - j)]);
      end
      data_o = {acc, data_i[127:8]};
    end
  end

endmodule

// File: rtl/kuznechik_cipher_param.sv
// Kuznyechik block cipher core with run-time round keys and an unrollable L stage.
// Define KUZNECHIK_DECRYPT_EN to compile in the inverse S-box, inverse R-steps
// and decrypt sequencing; otherwise every block is encrypted.
module kuznechik_cipher_param
  import kuznechik_pkg::*;
#(
  parameter int L_UNROLL = 1
) (
  input logic                     clk_i,
  input logic                     resetn_i,
  kuznechik_cipher_param_if.slave host_if
);

  localparam int         L_STEPS    = 16 / L_UNROLL;
  localparam logic [3:0] LAST_STEP  = 4'(L_STEPS - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUND_KEYS - 1);

  if (L_UNROLL != 1 && L_UNROLL != 2 && L_UNROLL != 4 && L_UNROLL != 8 && L_UNROLL != 16) begin : gBadUnroll
    $error("kuznechik_cipher_param: L_UNROLL must be 1, 2, 4, 8 or 16");
  end

  state_t       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   step_q, step_d;
  logic         mode_q, mode_d;
  logic [127:0] keyRam_q [NUM_ROUND_KEYS];

  logic [127:0] sFwd;
  logic [127:0] sOut;
  logic [127:0] lOut;
  logic [127:0] fwdChain [L_UNROLL+1];
  logic         acceptState;

  assign acceptState = (state_q == IDLE) || (state_q == FINISH);

  // Round keys are only writable while no block is in flight
  always_ff @(posedge clk_i) begin
    if (host_if.key_we_i && acceptState && (host_if.key_addr_i < 4'(NUM_ROUND_KEYS))) begin
      keyRam_q[host_if.key_addr_i] <= host_if.key_data_i;
    end
  end

  // Forward S-box applied to every byte of the working state
  always_comb begin
    sFwd = '0;
    for (int i = 0; i < 16; i++) begin
      sFwd[8*i +: 8] = S_BOX[data_q[8*i +: 8]];
    end
  end

  assign fwdChain[0] = data_q;
  for (genvar u = 0; u < L_UNROLL; u++) begin : gFwdChain
    kuznechik_r_step #(.INVERSE(1'b0)) uStep (
      .data_i (fwdChain[u]),
      .data_o (fwdChain[u+1])
    );
  end

`ifdef KUZNECHIK_DECRYPT_EN
  logic [127:0] sInv;
  logic [127:0] invChain [L_UNROLL+1];

  // Inverse S-box applied to every byte of the working state
  always_comb begin
    sInv = '0;
    for (int i = 0; i < 16; i++) begin
      sInv[8*i +: 8] = S_BOX_INV[data_q[8*i +: 8]];
    end
  end

  assign invChain[0] = data_q;
  for (genvar u = 0; u < L_UNROLL; u++) begin : gInvChain
    kuznechik_r_step #(.INVERSE(1'b1)) uStep (
      .data_i (invChain[u]),
      .data_o (invChain[u+1])
    );
  end

  assign sOut = mode_q ? sInv : sFwd;
  assign lOut = mode_q ? invChain[L_UNROLL] : fwdChain[L_UNROLL];
`else
  assign sOut = sFwd;
  assign lOut = fwdChain[L_UNROLL];
`endif

  // State, working block and counters; reset abandons any block in flight
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      round_q <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  // Round sequencing: encrypt runs KEY,S,L per round; decrypt runs L,S,KEY after an initial KEY
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    round_d = round_q;
    step_d  = step_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE, FINISH: begin
        if (host_if.request_i) begin
          state_d = KEY;
          data_d  = host_if.data_i;
          step_d  = '0;
`ifdef KUZNECHIK_DECRYPT_EN
          mode_d  = host_if.decrypt_i;
          round_d = host_if.decrypt_i ? LAST_ROUND : 4'd0;
`else
          mode_d  = 1'b0;
          round_d = 4'd0;
`endif
        end else if ((state_q == FINISH) && host_if.ack_i) begin
          state_d = IDLE;
        end
      end
      KEY: begin
        data_d = data_q ^ keyRam_q[round_q];
        if (mode_q) begin
          state_d = (round_q == 4'd0) ? FINISH : L;
        end else begin
          state_d = (round_q == LAST_ROUND) ? FINISH : S;
        end
      end
      S: begin
        data_d = sOut;
        if (mode_q) begin
          state_d = KEY;
          round_d = round_q - 4'd1;
        end else begin
          state_d = L;
        end
      end
      L: begin
        data_d = lOut;
        if (step_q == LAST_STEP) begin
          step_d = '0;
          if (mode_q) begin
            state_d = S;
          end else begin
            state_d = KEY;
            round_d = round_q + 4'd1;
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign host_if.data_o  = data_q;
  assign host_if.valid_o = (state_q == FINISH);
  assign host_if.busy_o  = acceptState ? host_if.request_i : 1'b1;

endmodule

// File: tb/tb_kuznechik_cipher_param.sv
// Scoreboard bench for kuznechik_cipher_param using the GOST R 34.12-2015 example.
module tb_kuznechik_cipher_param;

  parameter int L_UNROLL = 1;
  localparam int N         = 9 * (2 + 16 / L_UNROLL) + 1;
  localparam int RST_CYCLE = (N > 60) ? 50 : N / 2;

  localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  kuznechik_cipher_param_if hostIf();

  kuznechik_cipher_param #(.L_UNROLL(L_UNROLL)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .host_if  (hostIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    bit           mustMatch;
    int           reqEdge;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           testsRun    = 0;
  int           testsFailed = 0;
  int           edgeCnt     = 0;
  bit           monPrevValid;
  exp_t         monEntry;
  logic [127:0] roundKeys [10];

  // Edge counter used to measure request-to-valid latency
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic checkDiffer(input string name, input logic [127:0] act, input logic [127:0] notExp);
    testsRun++;
    if (act === notExp || $isunknown(act)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected any value other than %h", name, act, notExp);
    end
  endtask

  // Monitor: on each rising valid_o pop the oldest expectation and compare data and latency
  initial begin
    monPrevValid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hostIf.valid_o === 1'b1 && !monPrevValid) begin
        if (sb.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_valid: got data %h, expected no result", hostIf.data_o);
        end else begin
          monEntry = sb.pop_front();
          if (monEntry.mustMatch) checkOutput({monEntry.name, "_data"}, hostIf.data_o, monEntry.data);
          else                    checkDiffer({monEntry.name, "_data"}, hostIf.data_o, monEntry.data);
          checkOutput({monEntry.name, "_latency"}, 128'(edgeCnt - monEntry.reqEdge), 128'(N));
        end
      end
      monPrevValid = (hostIf.valid_o === 1'b1);
    end
  end

  task automatic pushExpect(input logic [127:0] data, input bit mustMatch, input string name);
    exp_t e;
    e.data      = data;
    e.mustMatch = mustMatch;
    e.reqEdge   = edgeCnt + 1;
    e.name      = name;
    sb.push_back(e);
  endtask

  // Issue one request; returns at the falling edge just after the sampling edge
  task automatic applyStimulus(input logic [127:0] data, input bit dec,
                               input logic [127:0] expData, input bit mustMatch, input string name);
    @(negedge clk);
    hostIf.request_i = 1'b1;
    hostIf.data_i    = data;
    hostIf.decrypt_i = dec;
    pushExpect(expData, mustMatch, name);
    @(negedge clk);
    hostIf.request_i = 1'b0;
    hostIf.data_i    = '0;
    hostIf.decrypt_i = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int k = 0;
    while (hostIf.valid_o !== 1'b1 && k < N + 10) begin
      @(negedge clk);
      k++;
    end
    if (hostIf.valid_o !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_timeout: valid_o still %b, expected 1 within %0d cycles", name, hostIf.valid_o, N + 10);
    end
  endtask

  task automatic ackResult(input string name);
    @(negedge clk);
    hostIf.ack_i = 1'b1;
    @(negedge clk);
    hostIf.ack_i = 1'b0;
    checkOutput({name, "_valid_after_ack"}, 128'(hostIf.valid_o), 128'(1'b0));
  endtask

  task automatic writeKey(input logic [3:0] addr, input logic [127:0] data);
    @(negedge clk);
    hostIf.key_we_i   = 1'b1;
    hostIf.key_addr_i = addr;
    hostIf.key_data_i = data;
    @(negedge clk);
    hostIf.key_we_i   = 1'b0;
  endtask

  task automatic runBlock(input logic [127:0] data, input bit dec,
                          input logic [127:0] expData, input bit mustMatch, input string name);
    applyStimulus(data, dec, expData, mustMatch, name);
    waitValid(name);
    ackResult(name);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    roundKeys[0] = 128'h8899aabbccddeeff0011223344556677;
    roundKeys[1] = 128'hfedcba98765432100123456789abcdef;
    roundKeys[2] = 128'hdb31485315694343228d6aef8cc78c44;
    roundKeys[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    roundKeys[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
    roundKeys[5] = 128'hbd079435165c6432b532e82834da581b;
    roundKeys[6] = 128'h51e640757e8745de705727265a0098b1;
    roundKeys[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    roundKeys[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    roundKeys[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

    hostIf.request_i  = 1'b0;
    hostIf.decrypt_i  = 1'b0;
    hostIf.data_i     = '0;
    hostIf.ack_i      = 1'b0;
    hostIf.key_we_i   = 1'b0;
    hostIf.key_addr_i = '0;
    hostIf.key_data_i = '0;

    #1 resetn = 1'b0;
    @(negedge clk);
    checkOutput("reset_data", hostIf.data_o, '0);
    checkOutput("reset_valid", 128'(hostIf.valid_o), 128'(1'b0));
    checkOutput("reset_busy", 128'(hostIf.busy_o), 128'(1'b0));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) writeKey(4'(i), roundKeys[i]);

    // ack in IDLE has no effect
    @(negedge clk);
    hostIf.ack_i = 1'b1;
    @(negedge clk);
    hostIf.ack_i = 1'b0;
    checkOutput("idle_ack_valid", 128'(hostIf.valid_o), 128'(1'b0));
    checkOutput("idle_ack_busy", 128'(hostIf.busy_o), 128'(1'b0));
    checkOutput("idle_ack_data", hostIf.data_o, '0);

    // Reference encryption with ack pulsed in S and a request pulsed in L
    applyStimulus(PT, 1'b0, CT, 1'b1, "enc_ref");
    checkOutput("enc_ref_latched", hostIf.data_o, PT);
    checkOutput("enc_ref_busy_key", 128'(hostIf.busy_o), 128'(1'b1));
    @(negedge clk);
    checkOutput("enc_ref_busy_s", 128'(hostIf.busy_o), 128'(1'b1));
    hostIf.ack_i = 1'b1;
    @(negedge clk);
    hostIf.ack_i = 1'b0;
    checkOutput("enc_ref_busy_l", 128'(hostIf.busy_o), 128'(1'b1));
    hostIf.request_i = 1'b1;
    hostIf.data_i    = CT;
    @(negedge clk);
    hostIf.request_i = 1'b0;
    hostIf.data_i    = '0;
    waitValid("enc_ref");
    checkOutput("finish_busy_idle_req", 128'(hostIf.busy_o), 128'(1'b0));
    @(negedge clk);
    checkOutput("finish_valid_held", 128'(hostIf.valid_o), 128'(1'b1));
    ackResult("enc_ref");

    // Back-to-back: request and ack together in FINISH, request wins
    applyStimulus(PT, 1'b0, CT, 1'b1, "b2b_first");
    waitValid("b2b_first");
    hostIf.request_i = 1'b1;
    hostIf.ack_i     = 1'b1;
    hostIf.data_i    = PT;
    #1;
    checkOutput("b2b_busy_comb", 128'(hostIf.busy_o), 128'(1'b1));
    pushExpect(CT, 1'b1, "b2b_second");
    @(negedge clk);
    hostIf.request_i = 1'b0;
    hostIf.ack_i     = 1'b0;
    hostIf.data_i    = '0;
    checkOutput("b2b_valid_drop", 128'(hostIf.valid_o), 128'(1'b0));
    checkOutput("b2b_busy", 128'(hostIf.busy_o), 128'(1'b1));
    waitValid("b2b_second");
    ackResult("b2b_second");

    // Decrypt path, or encryption of the same stimulus when decrypt is compiled out
`ifdef KUZNECHIK_DECRYPT_EN
    runBlock(CT, 1'b1, PT, 1'b1, "dec_ct");
    runBlock(PT, 1'b1, CT, 1'b0, "dec_pt");
`else
    runBlock(CT, 1'b1, PT, 1'b0, "dec_ct_as_enc");
    runBlock(PT, 1'b1, CT, 1'b1, "dec_pt_as_enc");
`endif

    // Asynchronous reset mid-block; keys survive
    applyStimulus(PT, 1'b0, CT, 1'b1, "rst_abandoned");
    repeat (RST_CYCLE - 1) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("rst_mid_data", hostIf.data_o, '0);
    checkOutput("rst_mid_valid", 128'(hostIf.valid_o), 128'(1'b0));
    checkOutput("rst_mid_busy", 128'(hostIf.busy_o), 128'(1'b0));
    void'(sb.pop_back());
    @(negedge clk);
    resetn = 1'b1;
    runBlock(PT, 1'b0, CT, 1'b1, "rst_after");

    // Key write while in L is ignored
    applyStimulus(PT, 1'b0, CT, 1'b1, "keywr_in_l");
    repeat (2) @(negedge clk);
    hostIf.key_we_i   = 1'b1;
    hostIf.key_addr_i = 4'd0;
    hostIf.key_data_i = '0;
    checkOutput("keywr_in_l_busy", 128'(hostIf.busy_o), 128'(1'b1));
    @(negedge clk);
    hostIf.key_we_i = 1'b0;
    waitValid("keywr_in_l");
    ackResult("keywr_in_l");

    // The same write in IDLE takes effect, then restore the reference key
    writeKey(4'd0, '0);
    runBlock(PT, 1'b0, CT, 1'b0, "keywr_idle");
    writeKey(4'd0, roundKeys[0]);
    runBlock(PT, 1'b0, CT, 1'b1, "key_restored");

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
